// File: rtl/fir_metric_pkg.sv
// Shared types and width helpers for the FIR error-metric blocks.
package fir_metric_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

   localparam int unsigned DefDw    = 16;
   localparam int unsigned DefLog2N = 10;

   function automatic int unsigned err_width(input int unsigned dw);
      return dw + 1;
   endfunction

   function automatic int unsigned sq_width(input int unsigned dw);
      return 2 * dw;
   endfunction

   // Wide enough that N squares of (2^DW - 1) never overflow.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned log2n);
      return 2 * dw + log2n;
   endfunction

endpackage

// File: rtl/fir_mse_monitor_if.sv
// Sample stream in, measurement results out, for the MSE monitor.
interface fir_mse_monitor_if
   import fir_metric_pkg::*;
#(
   parameter int unsigned DW = DefDw
) ();

   logic                    start;
   logic                    sample_valid;
   logic [DW-1:0]           y_approx;
   logic [DW-1:0]           y_exact;
   logic                    busy;
   logic                    mse_valid;
   logic [sq_width(DW)-1:0] mse;
   logic [DW:0]             err_max;

   modport master (
      output start, sample_valid, y_approx, y_exact,
      input  busy, mse_valid, mse, err_max
   );

   modport slave (
      input  start, sample_valid, y_approx, y_exact,
      output busy, mse_valid, mse, err_max
   );

endinterface

// File: rtl/sq_err_pipe.sv
// Two-stage error pipe: S1 registers |exact - approx|, S2 registers its square.
module sq_err_pipe
   import fir_metric_pkg::*;
#(
   parameter int unsigned DW = DefDw
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic                    in_valid,
   input  logic [DW-1:0]           y_exact,
   input  logic [DW-1:0]           y_approx,
   output logic                    s1_valid,
   output logic [DW:0]             s1_abs,
   output logic                    s2_valid,
   output logic [sq_width(DW)-1:0] s2_sq
);

   localparam int unsigned ErrW = err_width(DW);
   localparam int unsigned SqW  = sq_width(DW);

   logic signed [ErrW-1:0] diff;
   logic        [ErrW-1:0] abs_d;
   logic        [ErrW-1:0] abs_q;
   logic        [SqW-1:0]  sq_q;
   logic                   v1_q, v2_q;

   assign diff  = $signed({y_exact[DW-1], y_exact}) - $signed({y_approx[DW-1], y_approx});
   // |diff| <= 2^DW - 1, so negation cannot overflow ErrW bits.
   assign abs_d = diff[ErrW-1] ? $unsigned(-diff) : $unsigned(diff);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         abs_q <= '0;
         sq_q  <= '0;
      end else begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         if (in_valid) abs_q <= abs_d;
         if (v1_q)     sq_q  <= SqW'(abs_q[DW-1:0]) * SqW'(abs_q[DW-1:0]);
      end
   end

   assign s1_valid = v1_q;
   assign s1_abs   = abs_q;
   assign s2_valid = v2_q;
   assign s2_sq    = sq_q;

endmodule

// File: rtl/fir_mse_monitor.sv
// Windowed MSE and peak-error monitor comparing approximate and exact FIR outputs.
module fir_mse_monitor
   import fir_metric_pkg::*;
#(
   parameter int unsigned DW     = DefDw,
   parameter int unsigned LOG2_N = DefLog2N
) (
   input logic              clk,
   input logic              rstN,
   fir_mse_monitor_if.slave bus
);

   localparam int unsigned ErrW = err_width(DW);
   localparam int unsigned SqW  = sq_width(DW);
   localparam int unsigned AccW = acc_width(DW, LOG2_N);

   state_e              state_q, state_d;
   logic [LOG2_N-1:0]   cnt_q;
   logic [AccW-1:0]     acc_q;
   logic [ErrW-1:0]     max_q;
   logic [SqW-1:0]      mse_q;
   logic [ErrW-1:0]     err_max_q;
   logic                s3_valid_q;

   logic                accept, clear, load, pipe_busy;
   logic                s1_valid, s2_valid;
   logic [ErrW-1:0]     s1_abs;
   logic [SqW-1:0]      s2_sq;

   assign accept    = (state_q == StAccum) && bus.sample_valid;
   assign pipe_busy = s1_valid | s2_valid | s3_valid_q;

   sq_err_pipe #(
      .DW(DW)
   ) u_pipe (
      .clk      (clk),
      .rstN     (rstN),
      .in_valid (accept),
      .y_exact  (bus.y_exact),
      .y_approx (bus.y_approx),
      .s1_valid (s1_valid),
      .s1_abs   (s1_abs),
      .s2_valid (s2_valid),
      .s2_sq    (s2_sq)
   );

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StAccum;
               clear   = 1'b1;
            end
         end
         StAccum: begin
            if (accept && (cnt_q == '1)) state_d = StDrain;
         end
         StDrain: begin
            if (!pipe_busy) begin
               state_d = StDone;
               load    = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         max_q      <= '0;
         s3_valid_q <= 1'b0;
         mse_q      <= '0;
         err_max_q  <= '0;
      end else begin
         state_q    <= state_d;
         s3_valid_q <= s2_valid;
         if (clear) begin
            cnt_q <= '0;
            acc_q <= '0;
            max_q <= '0;
         end else begin
            if (accept)                       cnt_q <= cnt_q + 1'b1;
            if (s2_valid)                     acc_q <= acc_q + AccW'(s2_sq);
            if (s1_valid && (s1_abs > max_q)) max_q <= s1_abs;
         end
         // Results are captured on entry to DONE so they are valid with the pulse.
         if (load) begin
            mse_q     <= acc_q[AccW-1:LOG2_N];
            err_max_q <= max_q;
         end
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.mse_valid = (state_q == StDone);
   assign bus.mse       = mse_q;
   assign bus.err_max   = err_max_q;

endmodule

// File: tb/tb_fir_mse_monitor.sv
// Directed bench for fir_mse_monitor with a 4-sample window.
module tb_fir_mse_monitor;

   localparam int unsigned DW     = 16;
   localparam int unsigned LOG2_N = 2;

   logic clk;
   logic rstN;
   int   vectors;
   int   miscompares;
   int   pulses;
   int   pulses_at;

   fir_mse_monitor_if #(.DW(DW)) bus ();

   fir_mse_monitor #(
      .DW     (DW),
      .LOG2_N (LOG2_N)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.mse_valid === 1'b1) pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [15:0] ye, input logic [15:0] ya, input int gap);
      bus.y_exact      = ye;
      bus.y_approx     = ya;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      repeat (gap) tick();
   endtask

   // Called just after the edge that accepted the last sample.
   task automatic wait_result(input string tag, input logic [31:0] exp_mse,
                              input logic [16:0] exp_max);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while ((bus.mse_valid !== 1'b1) && (lat < 20));
      chk({tag, "_latency"}, 64'(lat), 64'd4);
      chk({tag, "_mse"}, 64'(bus.mse), 64'(exp_mse));
      chk({tag, "_err_max"}, 64'(bus.err_max), 64'(exp_max));
      chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
      tick();
      chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
      chk({tag, "_valid_after"}, 64'(bus.mse_valid), 64'd0);
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      pulses           = 0;
      rstN             = 1'b0;
      bus.start        = 1'b0;
      bus.sample_valid = 1'b0;
      bus.y_exact      = '0;
      bus.y_approx     = '0;
      repeat (2) tick();
      rstN = 1'b1;
      tick();

      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_valid", 64'(bus.mse_valid), 64'd0);
      chk("rst_mse", 64'(bus.mse), 64'd0);
      chk("rst_err_max", 64'(bus.err_max), 64'd0);

      // Zero error
      pulses_at = pulses;
      do_start();
      chk("t1_busy_start", 64'(bus.busy), 64'd1);
      repeat (4) send(16'd100, 16'd100, 0);
      wait_result("t1", 32'd0, 17'd0);
      chk("t1_pulses", 64'(pulses - pulses_at), 64'd1);

      // +4 / -4 alternating
      do_start();
      send(16'd10, 16'd6, 0);
      send(16'd6, 16'd10, 0);
      send(16'd10, 16'd6, 0);
      send(16'd6, 16'd10, 0);
      wait_result("t2", 32'd16, 17'd4);

      // Full-scale difference
      do_start();
      repeat (4) send(16'h7fff, 16'h8000, 0);
      wait_result("t3", 32'd4294836225, 17'd65535);

      // Gapped samples with a stray start mid-window
      pulses_at = pulses;
      do_start();
      send(16'd5, 16'd4, 3);
      send(16'd4, 16'd6, 2);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t4_busy_mid", 64'(bus.busy), 64'd1);
      send(16'd7, 16'd7, 3);
      send(16'hfff0, 16'hfff0, 0);
      wait_result("t4", 32'd1, 17'd2);
      chk("t4_pulses", 64'(pulses - pulses_at), 64'd1);

      // Reset mid-window
      pulses_at = pulses;
      do_start();
      send(16'd3, 16'd0, 0);
      send(16'd3, 16'd0, 0);
      rstN = 1'b0;
      #2;
      chk("t5_rst_busy", 64'(bus.busy), 64'd0);
      chk("t5_rst_mse", 64'(bus.mse), 64'd0);
      chk("t5_rst_valid", 64'(bus.mse_valid), 64'd0);
      repeat (2) tick();
      rstN = 1'b1;
      repeat (6) tick();
      chk("t5_no_pulse", 64'(pulses - pulses_at), 64'd0);
      chk("t5_idle_busy", 64'(bus.busy), 64'd0);
      do_start();
      repeat (4) send(16'd7, 16'd4, 0);
      wait_result("t5", 32'd9, 17'd3);

      // Samples while idle are ignored
      pulses_at = pulses;
      bus.y_exact      = 16'd200;
      bus.y_approx     = 16'd0;
      bus.sample_valid = 1'b1;
      repeat (5) tick();
      chk("t6_busy", 64'(bus.busy), 64'd0);
      bus.sample_valid = 1'b0;
      repeat (6) tick();
      chk("t6_busy_late", 64'(bus.busy), 64'd0);
      chk("t6_mse", 64'(bus.mse), 64'd9);
      chk("t6_err_max", 64'(bus.err_max), 64'd3);
      chk("t6_pulses", 64'(pulses - pulses_at), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fir_mse_monitor.md
Name: fir_mse_monitor

Overview:
Error-metric consumer sitting at the output of the approximate-adder FIR datapath. It takes the approximate filter output and the exact (golden) filter output in parallel and computes the mean squared error over a window of 2^LOG2_N valid samples. It also tracks the peak absolute error over the same window. It is the receiving end of the FIR sample stream and is used for on-chip MSE characterisation of each approximate adder variant.

Parameters:
DW, 16, sample width of both input streams (signed two's complement)
LOG2_N, 10, log2 of window length; N = 2^LOG2_N samples per measurement

Ports:
clk  in  1  system clock, all state updates on rising edge
rstN  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a new measurement window
sample_valid  in  1  y_approx and y_exact valid this cycle; caller guarantees both streams are time-aligned
y_approx  in  DW  signed output of approximate FIR
y_exact  in  DW  signed output of exact FIR
busy  out  1  high from accepted start until the cycle mse_valid is asserted (inclusive)
mse_valid  out  1  one-cycle pulse; mse and err_max valid from this cycle
mse  out  2*DW  floor(sum of squared errors / N), unsigned
err_max  out  DW+1  max |y_exact - y_approx| over the window, unsigned

Behaviour:
- Reset (rstN low, asynchronous): state IDLE; busy=0, mse_valid=0, mse=0, err_max=0; accumulator, sample counter, pipeline registers and pipeline valid bits cleared. Reset mid-window aborts the measurement with no mse_valid.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: sample_valid ignored. start=1 -> clear accumulator, counter and running max; go to ACCUM; busy=1 from the next cycle. mse/err_max keep their previous values.
- ACCUM: each cycle with sample_valid=1 the sample pair is accepted and the counter is incremented. On acceptance of the N-th sample, go to DRAIN. Gaps in sample_valid are allowed with no limit.
- DRAIN: no further samples accepted. Wait until the pipeline valid bits are empty, then go to DONE.
- DONE (single cycle): mse = acc >> LOG2_N, err_max = running max, mse_valid=1, busy=1. Next cycle -> IDLE with busy=0 and mse_valid=0.
- start while busy=1 is ignored; no restart and no error flag.
- Datapath pipeline, 3 stages, each with a valid bit:
  - S1: e = sign-extend(y_exact) - sign-extend(y_approx), DW+1 bits signed; |e| computed.
  - S2: sq = |e|*|e|, 2*DW bits unsigned; no overflow, since |e| <= 2^DW - 1. Running max updated with |e|.
  - S3: acc += sq; acc is 2*DW+LOG2_N bits unsigned and cannot overflow within one window.
- Latency: N-th sample accepted at cycle t -> mse_valid high at cycle t+4.
- Division is exact truncation (floor) by shift; no rounding.

Decomposition:
- Package fir_metric_pkg holds:
  - the state enum type (IDLE/ACCUM/DRAIN/DONE);
  - localparams for the error width (DW+1), square width (2*DW) and accumulator width (2*DW+LOG2_N) as functions of DW and LOG2_N.
- One natural sub-module, sq_err_pipe: the S1/S2 difference/abs/square stages with their valid propagation.
- The top level holds the FSM, counter, accumulator, running max and output registers.

Test Plan:
- LOG2_N=2. start, then 4 valid pairs (y_exact=100, y_approx=100) -> mse_valid at t+4 with mse=0, err_max=0; busy falls the cycle after.
- LOG2_N=2. 4 pairs with differences +4, -4, +4, -4 (e.g. 10/6, 6/10) -> mse=16, err_max=4.
- LOG2_N=2. 4 pairs y_exact=32767, y_approx=-32768 -> mse=4294836225 (65535^2), err_max=65535, no accumulator overflow.
- LOG2_N=2. Differences 1, 2, 0, 0 with 3 idle cycles between each valid, plus an extra start pulse mid-window -> mse=1 (floor 5/4), err_max=2; extra start ignored; exactly one mse_valid pulse.
- LOG2_N=2. Assert rstN low after 2 samples accepted -> busy=0, mse=0, mse_valid never pulses. Then a fresh start and 4 pairs with difference 3 -> mse=9.
- sample_valid pulses while IDLE (no start) -> no state change, busy=0, mse unchanged from its previous value.
